// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: ResultSrc values, the
// priority ladder that picks stage controls, and the control bundle.
package hazard_pkg;

   typedef enum logic [1:0] {
      RESULT_SRC_ALU  = 2'b00,
      RESULT_SRC_LOAD = 2'b01,
      RESULT_SRC_PC4  = 2'b10
   } result_src_e;

   // Listed highest priority first; reset overrides everything.
   typedef enum logic [2:0] {
      PRI_RESET,
      PRI_FREEZE,
      PRI_FLUSH,
      PRI_STALL,
      PRI_RUN
   } hazard_pri_e;

   typedef struct packed {
      logic fen;
      logic den;
      logic een;
      logic men;
      logic rstd;
      logic rste;
   } stage_ctl_t;

   function automatic stage_ctl_t ctl_for(input hazard_pri_e pri);
      stage_ctl_t c;
      c = '{fen: 1'b1, den: 1'b1, een: 1'b1, men: 1'b1, rstd: 1'b0, rste: 1'b0};
      case (pri)
         PRI_RESET:  c = '{fen: 1'b0, den: 1'b0, een: 1'b0, men: 1'b0, rstd: 1'b1, rste: 1'b1};
         PRI_FREEZE: c = '{fen: 1'b0, den: 1'b0, een: 1'b0, men: 1'b0, rstd: 1'b0, rste: 1'b0};
         PRI_FLUSH:  c = '{fen: 1'b1, den: 1'b1, een: 1'b1, men: 1'b1, rstd: 1'b1, rste: 1'b1};
         PRI_STALL:  c = '{fen: 1'b0, den: 1'b0, een: 1'b1, men: 1'b1, rstd: 1'b0, rste: 1'b1};
         default:    c = '{fen: 1'b1, den: 1'b1, een: 1'b1, men: 1'b1, rstd: 1'b0, rste: 1'b0};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: pipeline status in, stage
// enables/flushes and the stall counter out.
interface hazard_ctrl_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic [1:0]       ResultSrcE;
   logic             RegWriteE;
   logic [REG_W-1:0] RDE;
   logic [REG_W-1:0] Rs1D;
   logic [REG_W-1:0] Rs2D;
   logic             PCSrcE;
   logic             mem_ready;
   logic             FEN;
   logic             DEN;
   logic             EEN;
   logic             MEN;
   logic             RSTD;
   logic             RSTE;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output ResultSrcE, RegWriteE, RDE, Rs1D, Rs2D, PCSrcE, mem_ready,
      input  FEN, DEN, EEN, MEN, RSTD, RSTE, stall_count
   );

   modport slave (
      input  ResultSrcE, RegWriteE, RDE, Rs1D, Rs2D, PCSrcE, mem_ready,
      output FEN, DEN, EEN, MEN, RSTD, RSTE, stall_count
   );
endinterface

// File: rtl/hazard_ctrl_load_tracker.sv
// Shift register of loads that have left Execute but whose data is not yet
// forwardable; reports, per entry, whether a Decode source matches.
module load_tracker #(
   parameter  int REG_W    = 5,
   parameter  int LOAD_LAT = 1,
   localparam int ENTRIES  = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               shift_en,
   input  logic               capture,
   input  logic [REG_W-1:0]   capture_rd,
   input  logic [REG_W-1:0]   rs1,
   input  logic [REG_W-1:0]   rs2,
   output logic [ENTRIES-1:0] entry_match
);

   if (LOAD_LAT > 1) begin : g_track
      logic [ENTRIES-1:0] valid_q;
      logic [REG_W-1:0]   rd_q [ENTRIES];

      // Entries only advance when the Memory stage advances, so a frozen
      // pipeline keeps every load at the same distance from writeback.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) rd_q[i] <= '0;
         end else if (shift_en) begin
            valid_q[0] <= capture;
            rd_q[0]    <= capture_rd;
            for (int i = 1; i < ENTRIES; i++) begin
               valid_q[i] <= valid_q[i-1];
               rd_q[i]    <= rd_q[i-1];
            end
         end
      end

      // Captured rd is never x0, so a valid entry cannot match a zero source.
      always_comb begin
         entry_match = '0;
         for (int i = 0; i < ENTRIES; i++)
            entry_match[i] = valid_q[i] && ((rd_q[i] == rs1) || (rd_q[i] == rs2));
      end
   end else begin : g_none
      logic unused_ok;
      assign unused_ok   = ^{clk, rst_n, shift_en, capture, capture_rd, rs1, rs2};
      assign entry_match = '0;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use and control-hazard controller: picks stage enables/flushes by
// priority and counts load-use stall cycles.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input logic          clk,
   input logic          rst_n,
   hazard_ctrl_if.slave hz
);

   localparam int ENTRIES = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic               load_in_e;
   logic               e_match;
   logic               load_use;
   logic [ENTRIES-1:0] entry_match;
   hazard_pri_e        pri;
   stage_ctl_t         ctl;
   logic [CNT_W-1:0]   cnt_q;

   assign load_in_e = (hz.ResultSrcE == RESULT_SRC_LOAD) && hz.RegWriteE && (hz.RDE != '0);
   assign e_match   = load_in_e && ((hz.RDE == hz.Rs1D) || (hz.RDE == hz.Rs2D));
   assign load_use  = e_match || (|entry_match);

   load_tracker #(
      .REG_W   (REG_W),
      .LOAD_LAT(LOAD_LAT)
   ) u_tracker (
      .clk        (clk),
      .rst_n      (rst_n),
      .shift_en   (ctl.men),
      .capture    (load_in_e),
      .capture_rd (hz.RDE),
      .rs1        (hz.Rs1D),
      .rs2        (hz.Rs2D),
      .entry_match(entry_match)
   );

   // A taken branch outranks a load-use hazard: the dependent Decode
   // instruction is on the wrong path and is flushed anyway.
   always_comb begin
      pri = PRI_RUN;
      if (!rst_n)              pri = PRI_RESET;
      else if (!hz.mem_ready)  pri = PRI_FREEZE;
      else if (hz.PCSrcE)      pri = PRI_FLUSH;
      else if (load_use)       pri = PRI_STALL;
   end

   assign ctl = ctl_for(pri);

   assign hz.FEN  = ctl.fen;
   assign hz.DEN  = ctl.den;
   assign hz.EEN  = ctl.een;
   assign hz.MEN  = ctl.men;
   assign hz.RSTD = ctl.rstd;
   assign hz.RSTE = ctl.rste;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if ((pri == PRI_STALL) && (cnt_q != CNT_MAX))
         cnt_q <= cnt_q + CNT_ONE;
   end

   assign hz.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: four controllers (LOAD_LAT 1/2/3 and a 2-bit counter
// variant) driven with identical inputs from tables, sequences and random.
module tb_hazard_ctrl;

   localparam int ND = 4;
   localparam int LAT  [ND] = '{1, 2, 3, 1};
   localparam int CMAX [ND] = '{65535, 65535, 65535, 3};

   // Control bundles ordered {FEN, DEN, EEN, MEN, RSTD, RSTE}
   localparam int C_RUN    = 6'b111100;
   localparam int C_STALL  = 6'b001101;
   localparam int C_FLUSH  = 6'b111111;
   localparam int C_FREEZE = 6'b000000;
   localparam int C_RESET  = 6'b000011;

   logic clk;
   logic rst_n;
   int   n_compared;
   int   n_mismatched;
   int   ctl_a [ND];
   int   cnt_a [ND];

   hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) if0 ();
   hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) if1 ();
   hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) if2 ();
   hazard_ctrl_if #(.REG_W(5), .CNT_W(2))  if3 ();

   hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .hz(if0));
   hazard_ctrl #(.REG_W(5), .LOAD_LAT(2), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .hz(if1));
   hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(16)) dut2 (.clk(clk), .rst_n(rst_n), .hz(if2));
   hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(2))  dut3 (.clk(clk), .rst_n(rst_n), .hz(if3));

   assign ctl_a[0] = int'({if0.FEN, if0.DEN, if0.EEN, if0.MEN, if0.RSTD, if0.RSTE});
   assign ctl_a[1] = int'({if1.FEN, if1.DEN, if1.EEN, if1.MEN, if1.RSTD, if1.RSTE});
   assign ctl_a[2] = int'({if2.FEN, if2.DEN, if2.EEN, if2.MEN, if2.RSTD, if2.RSTE});
   assign ctl_a[3] = int'({if3.FEN, if3.DEN, if3.EEN, if3.MEN, if3.RSTD, if3.RSTE});
   assign cnt_a[0] = int'(if0.stall_count);
   assign cnt_a[1] = int'(if1.stall_count);
   assign cnt_a[2] = int'(if2.stall_count);
   assign cnt_a[3] = int'(if3.stall_count);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] rsrc;
      logic       rw;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       pcsrc;
      logic       ready;
      int         exp_ctl;
      int         exp_cnt;
   } vec_t;

   vec_t vecs [10];

   // Random-phase reference: pending loads as (rd, cycles of hazard left)
   int         left [ND][4];
   logic [4:0] prd  [ND][4];
   int         mcnt [ND];

   task automatic applyStimulus(input logic [1:0] rsrc, input logic rw, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic pcsrc, input logic ready);
      if0.ResultSrcE = rsrc; if0.RegWriteE = rw; if0.RDE = rd; if0.Rs1D = rs1; if0.Rs2D = rs2;
      if0.PCSrcE = pcsrc; if0.mem_ready = ready;
      if1.ResultSrcE = rsrc; if1.RegWriteE = rw; if1.RDE = rd; if1.Rs1D = rs1; if1.Rs2D = rs2;
      if1.PCSrcE = pcsrc; if1.mem_ready = ready;
      if2.ResultSrcE = rsrc; if2.RegWriteE = rw; if2.RDE = rd; if2.Rs1D = rs1; if2.Rs2D = rs2;
      if2.PCSrcE = pcsrc; if2.mem_ready = ready;
      if3.ResultSrcE = rsrc; if3.RegWriteE = rw; if3.RDE = rd; if3.Rs1D = rs1; if3.Rs2D = rs2;
      if3.PCSrcE = pcsrc; if3.mem_ready = ready;
   endtask

   task automatic checkOutput(input string name, input int d, input int act, input int exp);
      n_compared++;
      if (act != exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
      end
   endtask

   // Entered and left at posedge+1; reset values are checked while rst_n is low.
   task automatic applyReset();
      rst_n = 1'b0;
      applyStimulus(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      #1;
      for (int d = 0; d < ND; d++) begin
         checkOutput("reset_ctl", d, ctl_a[d], C_RESET);
         checkOutput("reset_cnt", d, cnt_a[d], 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      rst_n        = 1'b0;
      applyStimulus(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      #2;

      vecs[0] = '{2'b01, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, C_STALL,  1};
      vecs[1] = '{2'b01, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b1, C_STALL,  1};
      vecs[2] = '{2'b01, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_RUN,    0};
      vecs[3] = '{2'b01, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, C_RUN,    0};
      vecs[4] = '{2'b00, 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b1, C_RUN,    0};
      vecs[5] = '{2'b01, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, C_FLUSH,  0};
      vecs[6] = '{2'b01, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, C_FREEZE, 0};
      vecs[7] = '{2'b01, 1'b1, 5'd7, 5'd8, 5'd9, 1'b0, 1'b1, C_RUN,    0};
      vecs[8] = '{2'b00, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, C_FLUSH,  0};
      vecs[9] = '{2'b10, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, C_RUN,    0};

      // Single-cycle decisions from a clean tracker; identical for every LOAD_LAT.
      for (int i = 0; i < 10; i++) begin
         applyReset();
         applyStimulus(vecs[i].rsrc, vecs[i].rw, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                       vecs[i].pcsrc, vecs[i].ready);
         @(negedge clk);
         for (int d = 0; d < ND; d++) checkOutput($sformatf("vec%0d_ctl", i), d, ctl_a[d], vecs[i].exp_ctl);
         nextCycle();
         for (int d = 0; d < ND; d++) checkOutput($sformatf("vec%0d_cnt", i), d, cnt_a[d], vecs[i].exp_cnt);
      end

      // Dependent instruction right behind lw x7 stalls exactly LOAD_LAT cycles.
      applyReset();
      applyStimulus(2'b01, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         for (int d = 0; d < ND; d++)
            checkOutput($sformatf("lat_c%0d", c), d, ctl_a[d], (c < LAT[d]) ? C_STALL : C_RUN);
         nextCycle();
         applyStimulus(2'b00, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1);
      end
      for (int d = 0; d < ND; d++) checkOutput("lat_cnt", d, cnt_a[d], LAT[d]);

      // Memory not ready for 4 cycles mid-stall: frozen, then the stall resumes.
      applyReset();
      applyStimulus(2'b01, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1);
      @(negedge clk);
      for (int d = 0; d < ND; d++) checkOutput("frz_first", d, ctl_a[d], C_STALL);
      nextCycle();
      applyStimulus(2'b00, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         for (int d = 0; d < ND; d++) checkOutput($sformatf("frz_c%0d", c), d, ctl_a[d], C_FREEZE);
         nextCycle();
      end
      for (int d = 0; d < ND; d++) checkOutput("frz_cnt_held", d, cnt_a[d], 1);
      applyStimulus(2'b00, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int d = 0; d < ND; d++)
            checkOutput($sformatf("frz_resume%0d", c), d, ctl_a[d], (c < LAT[d] - 1) ? C_STALL : C_RUN);
         nextCycle();
      end
      for (int d = 0; d < ND; d++) checkOutput("frz_cnt", d, cnt_a[d], LAT[d]);

      // Reset in the middle of a LOAD_LAT=3 stall drops the tracked load.
      applyReset();
      applyStimulus(2'b01, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1);
      nextCycle();
      applyStimulus(2'b00, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("rst_mid_pre", 2, ctl_a[2], C_STALL);
      nextCycle();
      applyReset();
      applyStimulus(2'b00, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1);
      @(negedge clk);
      for (int d = 0; d < ND; d++) checkOutput("rst_mid_after", d, ctl_a[d], C_RUN);
      nextCycle();

      // Continuous load-use hazards: the 2-bit counter saturates at 3.
      applyReset();
      applyStimulus(2'b01, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
      for (int c = 0; c < 5; c++) begin
         nextCycle();
         checkOutput($sformatf("sat_c%0d", c), 3, cnt_a[3], (c + 1 < 3) ? c + 1 : 3);
      end
      for (int d = 0; d < 3; d++) checkOutput("sat_wide", d, cnt_a[d], 5);

      // Random traffic against the pending-load model.
      applyReset();
      for (int d = 0; d < ND; d++) begin
         mcnt[d] = 0;
         for (int k = 0; k < 4; k++) begin
            left[d][k] = 0;
            prd[d][k]  = '0;
         end
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic [1:0] rsrc;
         logic       rw, pcsrc, ready, ld, haz;
         logic [4:0] rd, rs1, rs2;
         int         exp_ctl;
         rsrc  = 2'($urandom_range(3));
         rw    = ($urandom_range(3) != 0);
         rd    = 5'($urandom_range(3));
         rs1   = 5'($urandom_range(3));
         rs2   = 5'($urandom_range(3));
         pcsrc = ($urandom_range(9) == 0);
         ready = ($urandom_range(7) != 0);
         applyStimulus(rsrc, rw, rd, rs1, rs2, pcsrc, ready);
         ld = (rsrc == 2'b01) && rw && (rd != 5'd0);
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            haz = ld && ((rd == rs1) || (rd == rs2));
            for (int k = 0; k < 4; k++)
               if (left[d][k] > 0 && ((prd[d][k] == rs1) || (prd[d][k] == rs2))) haz = 1'b1;
            exp_ctl = !ready ? C_FREEZE : pcsrc ? C_FLUSH : haz ? C_STALL : C_RUN;
            checkOutput("rnd_ctl", d, ctl_a[d], exp_ctl);
            checkOutput("rnd_cnt", d, cnt_a[d], mcnt[d]);
            if (exp_ctl == C_STALL && mcnt[d] < CMAX[d]) mcnt[d]++;
            if (ready) begin
               for (int k = 0; k < 4; k++) if (left[d][k] > 0) left[d][k]--;
               if (ld && LAT[d] > 1) begin
                  for (int k = 0; k < 4; k++) begin
                     if (left[d][k] == 0) begin
                        left[d][k] = LAT[d] - 1;
                        prd[d][k]  = rd;
                        break;
                     end
                  end
               end
            end
         end
         nextCycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
